// File: rtl/clefia_round_sched_if.sv
// Block I/O, round-key store and shared F-unit signals of the CLEFIA round scheduler.
// The slave modport is the scheduler, the master modport is its environment.
interface clefia_round_sched_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [1:0]   klen;
    logic         dec;
    logic [127:0] wk;
    logic [5:0]   rk_idx;
    logic [31:0]  rk_data;
    logic         f_en;
    logic         f_sel;
    logic [31:0]  f_x;
    logic [31:0]  f_rk;
    logic [31:0]  f_y;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, klen, dec, wk, rk_data, f_y, out_ready,
        input  in_ready, rk_idx, f_en, f_sel, f_x, f_rk, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, klen, dec, wk, rk_data, f_y, out_ready,
        output in_ready, rk_idx, f_en, f_sel, f_x, f_rk, out_valid, out_data
    );
endinterface

// File: rtl/clefia_round_sched.sv
// Iterative CLEFIA GFN4,r scheduler driving one shared F unit (F0 then F1 per round).
// Optional decryption path is built only when CLEFIA_DEC_EN is defined.
module clefia_round_sched #(
    parameter int F_LAT = 0
) (
    input logic                 clk,
    input logic                 rst_n,
    clefia_round_sched_if.slave bus
);
    typedef enum logic [1:0] {IDLE, F0, F1, OUT} state_t;

    state_t       state, state_nxt;
    logic [31:0]  t0, t1, t2, t3;
    logic [31:0]  t0_nxt, t1_nxt, t2_nxt, t3_nxt, t3_x;
    logic [4:0]   rnd, rnd_nxt, last_rnd, last_rnd_in, ridx;
    logic         lat_cnt, lat_nxt, last_cyc;
    logic         ready_q, accept;
    logic [31:0]  wk_in_a, wk_in_b, wk_out_a, wk_out_b;
    logic         f_en_q, f_sel_q, out_valid_q;
    logic [31:0]  f_x_q;
    logic [5:0]   rk_idx_q;
    logic [127:0] out_data_q;

    assign accept = (state == IDLE) && bus.in_valid && ready_q;

    always_comb begin
        case (bus.klen)
            2'd1:    last_rnd_in = 5'd21;
            2'd2:    last_rnd_in = 5'd25;
            default: last_rnd_in = 5'd17;
        endcase
    end

`ifdef CLEFIA_DEC_EN
    logic       dec_q, dec_use;
    logic [4:0] last_rnd_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            dec_q <= 1'b0;
        else if (accept)
            dec_q <= bus.dec;
    end

    // On the accept cycle the mode and round count are not latched yet.
    assign dec_use      = (state == IDLE) ? bus.dec : dec_q;
    assign last_rnd_use = (state == IDLE) ? last_rnd_in : last_rnd;
    assign wk_in_a      = bus.dec ? bus.wk[63:32]  : bus.wk[127:96];
    assign wk_in_b      = bus.dec ? bus.wk[31:0]   : bus.wk[95:64];
    assign wk_out_a     = dec_q   ? bus.wk[127:96] : bus.wk[63:32];
    assign wk_out_b     = dec_q   ? bus.wk[95:64]  : bus.wk[31:0];
    assign ridx         = dec_use ? (last_rnd_use - rnd_nxt) : rnd_nxt;
`else
    assign wk_in_a  = bus.wk[127:96];
    assign wk_in_b  = bus.wk[95:64];
    assign wk_out_a = bus.wk[63:32];
    assign wk_out_b = bus.wk[31:0];
    assign ridx     = rnd_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // The final F1 cycle folds the T3 update and the branch rotation into one write.
    always_comb begin
        state_nxt = state;
        t0_nxt    = t0;
        t1_nxt    = t1;
        t2_nxt    = t2;
        t3_nxt    = t3;
        rnd_nxt   = rnd;
        lat_nxt   = 1'b0;
        t3_x      = t3 ^ bus.f_y;
        last_cyc  = (F_LAT == 0) || lat_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = F0;
                    rnd_nxt   = '0;
                    t0_nxt    = bus.in_data[127:96];
                    t1_nxt    = bus.in_data[95:64] ^ wk_in_a;
                    t2_nxt    = bus.in_data[63:32];
                    t3_nxt    = bus.in_data[31:0] ^ wk_in_b;
                end
            end
            F0: begin
                if (last_cyc) begin
                    t1_nxt    = t1 ^ bus.f_y;
                    state_nxt = F1;
                end else begin
                    lat_nxt = 1'b1;
                end
            end
            F1: begin
                if (!last_cyc) begin
                    lat_nxt = 1'b1;
                end else if (rnd == last_rnd) begin
                    t3_nxt    = t3_x;
                    state_nxt = OUT;
                end else begin
                    rnd_nxt   = rnd + 5'd1;
                    state_nxt = F0;
`ifdef CLEFIA_DEC_EN
                    if (dec_q)
                        {t0_nxt, t1_nxt, t2_nxt, t3_nxt} = {t3_x, t0, t1, t2};
                    else
                        {t0_nxt, t1_nxt, t2_nxt, t3_nxt} = {t1, t2, t3_x, t0};
`else
                    {t0_nxt, t1_nxt, t2_nxt, t3_nxt} = {t1, t2, t3_x, t0};
`endif
                end
            end
            OUT: begin
                if (bus.out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from next-state values; F-side outputs hold outside F0/F1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t0          <= '0;
            t1          <= '0;
            t2          <= '0;
            t3          <= '0;
            rnd         <= '0;
            last_rnd    <= '0;
            lat_cnt     <= 1'b0;
            ready_q     <= 1'b0;
            f_en_q      <= 1'b0;
            f_sel_q     <= 1'b0;
            f_x_q       <= '0;
            rk_idx_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            t0          <= t0_nxt;
            t1          <= t1_nxt;
            t2          <= t2_nxt;
            t3          <= t3_nxt;
            rnd         <= rnd_nxt;
            lat_cnt     <= lat_nxt;
            ready_q     <= (state_nxt == IDLE);
            f_en_q      <= (state_nxt == F0) || (state_nxt == F1);
            out_valid_q <= (state_nxt == OUT);
            if (accept)
                last_rnd <= last_rnd_in;
            if (state_nxt == F0) begin
                f_sel_q  <= 1'b0;
                f_x_q    <= t0_nxt;
                rk_idx_q <= {ridx, 1'b0};
            end else if (state_nxt == F1) begin
                f_sel_q  <= 1'b1;
                f_x_q    <= t2_nxt;
                rk_idx_q <= {ridx, 1'b1};
            end
            if ((state_nxt == OUT) && (state != OUT))
                out_data_q <= {t0_nxt, t1_nxt ^ wk_out_a, t2_nxt, t3_nxt ^ wk_out_b};
        end
    end

    assign bus.in_ready  = ready_q;
    assign bus.f_en      = f_en_q;
    assign bus.f_sel     = f_sel_q;
    assign bus.f_x       = f_x_q;
    assign bus.f_rk      = bus.rk_data;
    assign bus.rk_idx    = rk_idx_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
endmodule
